// File: rtl/spi_reg_ctrl_if.sv
// Register request/response port between a register client and spi_reg_ctrl.
// The client drives the request and consumes the response; the sequencer does the opposite.
interface spi_reg_ctrl_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer in front of the SPI master: one request at a time becomes one
// frame pushed into the master, with a timeout that soft-resets the master and returns an error.
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned ABORT_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_ctrl_if.slave        bus,
  output logic [31:0]          spi_tdata,
  output logic                 spi_tvalid,
  input  logic                 spi_tready,
  input  logic [31:0]          spi_rdata,
  input  logic                 spi_rvalid,
  output logic                 spi_rready,
  input  logic [15:0]          wr_data_num,
  output logic [1:0]           w_r_mode,
  output logic [5:0]           wr_width,
  output logic [5:0]           rd_width,
  output logic [15:0]          rd_target_num,
  output logic                 soft_rst_n
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StSend  = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;
  localparam logic [2:0] StAbort = 3'd5;

  logic [2:0]  state;
  logic        rw_q;
  logic [15:0] snap_q;
  logic [31:0] cnt;
  logic        timeout_hit;
  logic        wait_done;
  logic        unused_rdata;

  assign unused_rdata = ^spi_rdata[31:DATA_W];

  // >= rather than == so a SEND handshake landing on the last allowed cycle still aborts in WAIT
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt >= TIMEOUT_CYC - 1);
  assign wait_done   = rw_q ? (spi_rvalid && spi_rready) : (wr_data_num != snap_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      rw_q          <= 1'b0;
      snap_q        <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      spi_tdata     <= '0;
      spi_tvalid    <= 1'b0;
      spi_rready    <= 1'b0;
      w_r_mode      <= 2'b01;
      wr_width      <= 6'(ADDR_W + 1 + DATA_W);
      rd_width      <= 6'(DATA_W);
      rd_target_num <= 16'd1;
      soft_rst_n    <= 1'b1;
    end else begin
      case (state)
        StIdle: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            bus.rsp_rdata <= '0;
            rw_q          <= bus.req_rw;
            snap_q        <= wr_data_num;
            rd_width      <= 6'(DATA_W);
            rd_target_num <= 16'd1;
            if (bus.req_rw) begin
              w_r_mode  <= 2'b10;
              wr_width  <= 6'(ADDR_W + 1);
              spi_tdata <= (32'd1 << ADDR_W) | 32'(bus.req_addr);
            end else begin
              w_r_mode  <= 2'b01;
              wr_width  <= 6'(ADDR_W + 1 + DATA_W);
              spi_tdata <= (32'(bus.req_addr) << DATA_W) | 32'(bus.req_wdata);
            end
            state <= StLoad;
          end
        end
        StLoad: begin
          spi_tvalid <= 1'b1;
          cnt        <= '0;
          state      <= StSend;
        end
        StSend: begin
          if (spi_tready) begin
            spi_tvalid <= 1'b0;
            spi_rready <= rw_q;
            cnt        <= cnt + 32'd1;
            state      <= StWait;
          end else if (timeout_hit) begin
            spi_tvalid <= 1'b0;
            spi_rready <= 1'b0;
            soft_rst_n <= 1'b0;
            cnt        <= '0;
            state      <= StAbort;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StWait: begin
          if (wait_done) begin
            if (rw_q) begin
              bus.rsp_rdata <= spi_rdata[DATA_W-1:0];
            end
            spi_rready    <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            state         <= StResp;
          end else if (timeout_hit) begin
            spi_tvalid <= 1'b0;
            spi_rready <= 1'b0;
            soft_rst_n <= 1'b0;
            cnt        <= '0;
            state      <= StAbort;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StAbort: begin
          if (cnt >= ABORT_CYC - 1) begin
            soft_rst_n    <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            state         <= StResp;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
